reg_xfer_seq: RTL and testbench

- Micro-sequencer that drives the CPU register file's write strobes and write data for register-transfer, increment/decrement and stack push/pull operations.
- Accepts one 4-bit operation at a time from the instruction decoder through a valid/ready handshake.
- Reads current register values back from the register file and runs the stack-page memory access for push/pull.
- Sits between the decoder, the register file and the memory bus.

---
 rtl/reg_xfer_seq_if.sv | 23 ++
 rtl/reg_xfer_seq.sv | 166 ++++++++++++++++
 tb/tb_reg_xfer_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/reg_xfer_seq_if.sv
// Decoder command handshake plus stack-page memory bus seen by reg_xfer_seq.
// master = sequencer side, slave = decoder/memory side.
interface reg_xfer_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    input  cmd_valid, cmd_op, mem_ack, mem_rdata,
    output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_op, mem_ack, mem_rdata,
    input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/reg_xfer_seq.sv
// Register-transfer / inc-dec / stack push-pull micro-sequencer; single-cycle ops retire
// the cycle after accept, stack ops wait on mem_ack with a bounded timeout.
module reg_xfer_seq #(
  parameter logic [7:0] STACK_PAGE  = 8'h01,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic       clk_2,
  input  logic       rst,
  reg_xfer_seq_if.master bus,
  input  logic [7:0] a_in,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  input  logic [7:0] sp_in,
  input  logic [7:0] status_in,
  output logic [7:0] data_in,
  output logic [7:0] data_status,
  output logic       accumulator_con,
  output logic       x_con,
  output logic       y_con,
  output logic       stack_pointer_con,
  output logic       status_con,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] OP_TAX = 4'h1, OP_TAY = 4'h2, OP_TXA = 4'h3, OP_TYA = 4'h4,
                         OP_TSX = 4'h5, OP_TXS = 4'h6, OP_INX = 4'h7, OP_INY = 4'h8,
                         OP_DEX = 4'h9, OP_DEY = 4'hA, OP_PHA = 4'hB, OP_PLA = 4'hC,
                         OP_PHP = 4'hD, OP_PLP = 4'hE;
  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, EXEC, PUSH_MEM, PUSH_SP, PULL_SP, PULL_MEM, PULL_WB} state_t;

  state_t     state, state_nxt;
  logic [3:0] op_q;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] rdata_q, rdata_nxt;
  logic       wr_flags;

  function automatic logic [7:0] nz_flags(input logic [7:0] st, input logic [7:0] r);
    logic [7:0] f;
    f    = st;
    f[7] = r[7];
    f[1] = (r == 8'h00);
    return f;
  endfunction

  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      op_q    <= 4'h0;
      cnt     <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rdata_q <= rdata_nxt;
      if (bus.cmd_ready && bus.cmd_valid)
        op_q <= bus.cmd_op;
    end
  end

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    rdata_nxt         = rdata_q;
    wr_flags          = 1'b0;
    bus.cmd_ready     = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = 16'h0000;
    bus.mem_wdata     = 8'h00;
    data_in           = 8'h00;
    data_status       = 8'h00;
    accumulator_con   = 1'b0;
    x_con             = 1'b0;
    y_con             = 1'b0;
    stack_pointer_con = 1'b0;
    status_con        = 1'b0;
    done              = 1'b0;
    err               = 1'b0;

    case (state)
      IDLE: begin
        // Reset gating keeps cmd_ready low while rst is held, not just after the first edge.
        bus.cmd_ready = rst;
        cnt_nxt       = 8'h00;
        if (bus.cmd_valid && rst) begin
          case (bus.cmd_op)
            OP_PHA, OP_PHP: state_nxt = PUSH_MEM;
            OP_PLA, OP_PLP: state_nxt = PULL_SP;
            default:        state_nxt = EXEC;
          endcase
        end
      end
      EXEC: begin
        done      = 1'b1;
        state_nxt = IDLE;
        case (op_q)
          OP_TAX: begin x_con = 1'b1; data_in = a_in;  wr_flags = 1'b1; end
          OP_TAY: begin y_con = 1'b1; data_in = a_in;  wr_flags = 1'b1; end
          OP_TXA: begin accumulator_con = 1'b1; data_in = x_in; wr_flags = 1'b1; end
          OP_TYA: begin accumulator_con = 1'b1; data_in = y_in; wr_flags = 1'b1; end
          OP_TSX: begin x_con = 1'b1; data_in = sp_in; wr_flags = 1'b1; end
          OP_TXS: begin stack_pointer_con = 1'b1; data_in = x_in; end
          OP_INX: begin x_con = 1'b1; data_in = x_in + 8'd1; wr_flags = 1'b1; end
          OP_INY: begin y_con = 1'b1; data_in = y_in + 8'd1; wr_flags = 1'b1; end
          OP_DEX: begin x_con = 1'b1; data_in = x_in - 8'd1; wr_flags = 1'b1; end
          OP_DEY: begin y_con = 1'b1; data_in = y_in - 8'd1; wr_flags = 1'b1; end
          // Stack ops only land in EXEC after an ack timeout: retire with error, no writes.
          OP_PHA, OP_PLA, OP_PHP, OP_PLP: err = 1'b1;
          default: ;
        endcase
      end
      PUSH_MEM: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {STACK_PAGE, sp_in};
        bus.mem_wdata = (op_q == OP_PHA) ? a_in : (status_in | 8'h30);
        if (bus.mem_ack)          state_nxt = PUSH_SP;
        else if (cnt == CNT_LAST) state_nxt = EXEC;
        else                      cnt_nxt   = cnt + 8'd1;
      end
      PUSH_SP: begin
        stack_pointer_con = 1'b1;
        data_in           = sp_in - 8'd1;
        done              = 1'b1;
        state_nxt         = IDLE;
      end
      PULL_SP: begin
        stack_pointer_con = 1'b1;
        data_in           = sp_in + 8'd1;
        cnt_nxt           = 8'h00;
        state_nxt         = PULL_MEM;
      end
      PULL_MEM: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {STACK_PAGE, sp_in};
        if (bus.mem_ack) begin
          rdata_nxt = bus.mem_rdata;
          state_nxt = PULL_WB;
        end else if (cnt == CNT_LAST) state_nxt = EXEC;
        else                          cnt_nxt   = cnt + 8'd1;
      end
      PULL_WB: begin
        done       = 1'b1;
        status_con = 1'b1;
        state_nxt  = IDLE;
        if (op_q == OP_PLA) begin
          accumulator_con = 1'b1;
          data_in         = rdata_q;
          data_status     = nz_flags(status_in, rdata_q);
        end else begin
          data_status = {rdata_q[7:6], 2'b10, rdata_q[3:0]};
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (wr_flags) begin
      status_con  = 1'b1;
      data_status = nz_flags(status_in, data_in);
    end
  end

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Directed bench for reg_xfer_seq: transfers, inc/dec wrap, push/pull, ack timeout, mid-op reset.
module tb_reg_xfer_seq;
  localparam int TMO = 16;

  logic       clk_2 = 1'b0;
  logic       rst   = 1'b0;
  logic [7:0] a_in, x_in, y_in, sp_in, status_in;
  logic [7:0] data_in, data_status;
  logic       accumulator_con, x_con, y_con, stack_pointer_con, status_con, done, err;
  int         tests = 0;
  int         fails = 0;

  reg_xfer_seq_if bus();

  reg_xfer_seq #(.STACK_PAGE(8'h01), .ACK_TIMEOUT(TMO)) dut (
    .clk_2(clk_2), .rst(rst), .bus(bus),
    .a_in(a_in), .x_in(x_in), .y_in(y_in), .sp_in(sp_in), .status_in(status_in),
    .data_in(data_in), .data_status(data_status),
    .accumulator_con(accumulator_con), .x_con(x_con), .y_con(y_con),
    .stack_pointer_con(stack_pointer_con), .status_con(status_con),
    .done(done), .err(err)
  );

  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #2;
  endtask

  task automatic issue(input logic [3:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'h0;
    #1;
  endtask

  task automatic test_reset();
    x_in = 8'h80; a_in = 8'h00; y_in = 8'h00; sp_in = 8'h00; status_in = 8'h00;
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    tick(); tick();
    tests++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_cmd_ready got %b exp 0", bus.cmd_ready); end
    tests++; if (done !== 1'b0 || bus.mem_req !== 1'b0 || x_con !== 1'b0) begin fails++; $display("FAIL rst_outputs got done=%b req=%b x_con=%b exp 0", done, bus.mem_req, x_con); end
    rst = 1'b1;
    #1;
    tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b exp 1", bus.cmd_ready); end
  endtask

  task automatic test_tax();
    a_in = 8'h00; x_in = 8'h80; status_in = 8'h24;
    issue(4'h1);
    tests++; if (x_con !== 1'b1 || accumulator_con !== 1'b0) begin fails++; $display("FAIL tax_strobe got x=%b a=%b exp x=1 a=0", x_con, accumulator_con); end
    tests++; if (data_in !== 8'h00) begin fails++; $display("FAIL tax_data got %h exp 00", data_in); end
    tests++; if (status_con !== 1'b1 || data_status !== 8'h26) begin fails++; $display("FAIL tax_status got con=%b st=%h exp con=1 st=26", status_con, data_status); end
    tests++; if (done !== 1'b1 || err !== 1'b0 || bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL tax_done got done=%b err=%b rdy=%b exp 1 0 0", done, err, bus.cmd_ready); end
    tick();
    tests++; if (done !== 1'b0 || x_con !== 1'b0 || bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL tax_after got done=%b x=%b rdy=%b exp 0 0 1", done, x_con, bus.cmd_ready); end
  endtask

  task automatic test_incdec();
    x_in = 8'h00; status_in = 8'h02;
    issue(4'h9);
    tests++; if (x_con !== 1'b1 || data_in !== 8'hFF) begin fails++; $display("FAIL dex got x=%b d=%h exp 1 FF", x_con, data_in); end
    tests++; if (data_status !== 8'h80) begin fails++; $display("FAIL dex_flags got %h exp 80", data_status); end
    tick();
    y_in = 8'hFF; status_in = 8'h80;
    issue(4'h8);
    tests++; if (y_con !== 1'b1 || data_in !== 8'h00 || data_status !== 8'h02) begin fails++; $display("FAIL iny_wrap got y=%b d=%h st=%h exp 1 00 02", y_con, data_in, data_status); end
    tick();
    x_in = 8'h40;
    issue(4'h6);
    tests++; if (stack_pointer_con !== 1'b1 || status_con !== 1'b0 || data_in !== 8'h40 || x_con !== 1'b0) begin fails++; $display("FAIL txs got sp=%b st=%b d=%h x=%b exp 1 0 40 0", stack_pointer_con, status_con, data_in, x_con); end
    tick();
    y_in = 8'h7E; status_in = 8'h00;
    issue(4'h4);
    tests++; if (accumulator_con !== 1'b1 || data_in !== 8'h7E || data_status !== 8'h00) begin fails++; $display("FAIL tya got a=%b d=%h st=%h exp 1 7E 00", accumulator_con, data_in, data_status); end
    tick();
  endtask

  task automatic test_pha();
    sp_in = 8'h00; a_in = 8'h5A;
    issue(4'hB);
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0100 || bus.mem_wdata !== 8'h5A) begin fails++; $display("FAIL pha_mem%0d got req=%b we=%b a=%h w=%h exp 1 1 0100 5A", i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      if (i == 2) bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      #1;
    end
    tests++; if (stack_pointer_con !== 1'b1 || data_in !== 8'hFF || done !== 1'b1 || status_con !== 1'b0) begin fails++; $display("FAIL pha_sp got sp=%b d=%h done=%b st=%b exp 1 FF 1 0", stack_pointer_con, data_in, done, status_con); end
    tests++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 8'h00) begin fails++; $display("FAIL pha_idle_bus got req=%b a=%h w=%h exp 0 0000 00", bus.mem_req, bus.mem_addr, bus.mem_wdata); end
    tick();
  endtask

  task automatic test_php_ack_at_expiry();
    sp_in = 8'h80; status_in = 8'h01;
    issue(4'hD);
    tests++; if (bus.mem_wdata !== 8'h31 || bus.mem_addr !== 16'h0180) begin fails++; $display("FAIL php_wdata got w=%h a=%h exp 31 0180", bus.mem_wdata, bus.mem_addr); end
    for (int i = 0; i < TMO; i++) begin
      if (i == TMO - 1) bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      #1;
    end
    tests++; if (stack_pointer_con !== 1'b1 || done !== 1'b1 || err !== 1'b0 || data_in !== 8'h7F) begin fails++; $display("FAIL php_late_ack got sp=%b done=%b err=%b d=%h exp 1 1 0 7F", stack_pointer_con, done, err, data_in); end
    tick();
  endtask

  task automatic test_plp();
    sp_in = 8'hFF; status_in = 8'h00;
    issue(4'hE);
    tests++; if (stack_pointer_con !== 1'b1 || data_in !== 8'h00 || status_con !== 1'b0 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL plp_sp got sp=%b d=%h st=%b req=%b exp 1 00 0 0", stack_pointer_con, data_in, status_con, bus.mem_req); end
    tick();
    sp_in = 8'h00;
    #1;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0100 || stack_pointer_con !== 1'b0) begin fails++; $display("FAIL plp_mem got req=%b we=%b a=%h sp=%b exp 1 0 0100 0", bus.mem_req, bus.mem_we, bus.mem_addr, stack_pointer_con); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hDF;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    #1;
    tests++; if (status_con !== 1'b1 || data_status !== 8'hEF || accumulator_con !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL plp_wb got st=%b ds=%h a=%b done=%b exp 1 EF 0 1", status_con, data_status, accumulator_con, done); end
    tick();
  endtask

  task automatic test_pla();
    sp_in = 8'h20; status_in = 8'h00;
    issue(4'hC);
    tick();
    sp_in = 8'h21;
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h00;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h55;
    #1;
    tests++; if (accumulator_con !== 1'b1 || data_in !== 8'h00 || data_status !== 8'h02 || status_con !== 1'b1) begin fails++; $display("FAIL pla_wb got a=%b d=%h ds=%h st=%b exp 1 00 02 1", accumulator_con, data_in, data_status, status_con); end
    tick();
  endtask

  task automatic test_pla_timeout();
    int  n;
    logic acc_seen;
    sp_in = 8'h10;
    issue(4'hC);
    tick();
    n = 0; acc_seen = 1'b0;
    while (bus.mem_req === 1'b1 && n < 64) begin
      if (accumulator_con !== 1'b0 || done !== 1'b0) acc_seen = 1'b1;
      n++;
      tick();
    end
    tests++; if (n !== TMO) begin fails++; $display("FAIL tmo_req_cycles got %0d exp %0d", n, TMO); end
    tests++; if (done !== 1'b1 || err !== 1'b1) begin fails++; $display("FAIL tmo_done_err got done=%b err=%b exp 1 1", done, err); end
    tests++; if (acc_seen || accumulator_con !== 1'b0 || status_con !== 1'b0 || stack_pointer_con !== 1'b0) begin fails++; $display("FAIL tmo_no_write got seen=%b a=%b st=%b sp=%b exp 0", acc_seen, accumulator_con, status_con, stack_pointer_con); end
    tick();
    tests++; if (err !== 1'b0 || done !== 1'b0 || bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL tmo_after got err=%b done=%b rdy=%b exp 0 0 1", err, done, bus.cmd_ready); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (done !== 1'b0 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL stray_ack got done=%b req=%b exp 0 0", done, bus.mem_req); end
  endtask

  task automatic test_reset_mid();
    sp_in = 8'h30; a_in = 8'h11;
    issue(4'hB);
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL mid_pre_req got %b exp 1", bus.mem_req); end
    rst = 1'b0;
    #1;
    tests++; if (bus.mem_req !== 1'b0 || stack_pointer_con !== 1'b0 || done !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.mem_addr !== 16'h0000) begin fails++; $display("FAIL mid_rst got req=%b sp=%b done=%b rdy=%b a=%h exp 0", bus.mem_req, stack_pointer_con, done, bus.cmd_ready, bus.mem_addr); end
    tick(); tick();
    rst = 1'b1;
    #1;
    tests++; if (bus.cmd_ready !== 1'b1 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL mid_release got rdy=%b req=%b exp 1 0", bus.cmd_ready, bus.mem_req); end
    issue(4'h0);
    tests++; if (done !== 1'b1 || accumulator_con !== 1'b0 || x_con !== 1'b0 || y_con !== 1'b0 || stack_pointer_con !== 1'b0 || status_con !== 1'b0) begin fails++; $display("FAIL nop got done=%b a=%b x=%b y=%b sp=%b st=%b exp 1 0 0 0 0 0", done, accumulator_con, x_con, y_con, stack_pointer_con, status_con); end
    tick();
  endtask

  initial begin
    test_reset();
    test_tax();
    test_incdec();
    test_pha();
    test_php_ack_at_expiry();
    test_plp();
    test_pla();
    test_pla_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
